// File: rtl/ttc_prescale_lite21.sv
// ttc_prescale_lite21: clock-enable prescaler for one TTC timer channel.
// Defining TTC_EXT_CLK_EN builds the synchronised external clock source.
module ttc_prescale_lite21 (
    input  logic        pclk21,
    input  logic        n_p_reset21,
    input  logic [6:0]  clk_ctrl_reg21,
    input  logic        count_en21,
    input  logic        ext_clk21,
    output logic        count_tick21,
    output logic [15:0] prescale_cnt21
);

    logic [15:0] mask;
    logic        evt;

    // Same result as ((2 << N) - 1) truncated to 16 bits, without the unused carry bit.
    assign mask = ~(16'hFFFE << clk_ctrl_reg21[4:1]);

`ifdef TTC_EXT_CLK_EN
    logic       s1;
    logic       s2;
    logic       s3;
    logic [1:0] prime;
    logic       rise;
    logic       fall;
    logic       ext_event;

    always_ff @(posedge pclk21 or negedge n_p_reset21) begin
        if (!n_p_reset21) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            prime <= 2'b00;
        end else begin
            s1 <= ext_clk21;
            s2 <= s1;
            s3 <= s2;
            if (prime != 2'b11) begin
                prime <= prime + 2'd1;
            end
        end
    end

    // prime holds off edge reporting until the pipe is filled with real samples.
    assign rise      = s2 & ~s3;
    assign fall      = ~s2 & s3;
    assign ext_event = (prime == 2'b11) & (clk_ctrl_reg21[6] ? fall : rise);
    assign evt       = clk_ctrl_reg21[5] ? ext_event : 1'b1;
`else
    logic unused_ext;

    assign unused_ext = ^{ext_clk21, clk_ctrl_reg21[6:5]};
    assign evt        = 1'b1;
`endif

    always_ff @(posedge pclk21 or negedge n_p_reset21) begin
        if (!n_p_reset21) begin
            count_tick21   <= 1'b0;
            prescale_cnt21 <= 16'h0000;
        end else if (!count_en21) begin
            count_tick21   <= 1'b0;
            prescale_cnt21 <= 16'h0000;
        end else if (!evt) begin
            count_tick21 <= 1'b0;
        end else if (!clk_ctrl_reg21[0]) begin
            count_tick21 <= 1'b1;
        end else begin
            // Masked compare keeps the tick within D events after a mid-count mask change.
            count_tick21   <= ((prescale_cnt21 & mask) == mask);
            prescale_cnt21 <= prescale_cnt21 + 16'd1;
        end
    end

endmodule

// File: tb/tb_ttc_prescale_lite21.sv
// Testbench for ttc_prescale_lite21: vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model (honours TTC_EXT_CLK_EN).
module tb_ttc_prescale_lite21;

    logic        pclk21 = 1'b0;
    logic        n_p_reset21 = 1'b0;
    logic [6:0]  clk_ctrl_reg21 = 7'h20;
    logic        count_en21 = 1'b0;
    logic        ext_clk21 = 1'b1;
    logic        count_tick21;
    logic [15:0] prescale_cnt21;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

`ifdef TTC_EXT_CLK_EN
    localparam bit EXT_BUILT = 1'b1;
`else
    localparam bit EXT_BUILT = 1'b0;
`endif

    ttc_prescale_lite21 dut (
        .pclk21         (pclk21),
        .n_p_reset21    (n_p_reset21),
        .clk_ctrl_reg21 (clk_ctrl_reg21),
        .count_en21     (count_en21),
        .ext_clk21      (ext_clk21),
        .count_tick21   (count_tick21),
        .prescale_cnt21 (prescale_cnt21)
    );

    always #5 pclk21 = ~pclk21;

    // ---------------- reference model ----------------
    int   m_cnt = 0;
    logic m_tick = 1'b0;
`ifdef TTC_EXT_CLK_EN
    logic [2:0] hist = 3'b000;   // [0] = sample at latest edge, [2] = two edges earlier
    int         nedge = 0;
`endif

    function automatic int divisor(input logic [6:0] c);
        return 1 << (int'(c[4:1]) + 1);
    endfunction

    function automatic logic model_event();
`ifdef TTC_EXT_CLK_EN
        logic e;
        if (nedge < 3) e = 1'b0;
        else if (clk_ctrl_reg21[6]) e = !hist[1] && hist[2];
        else e = hist[1] && !hist[2];
        return clk_ctrl_reg21[5] ? e : 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic nxt_tick(input logic en, input logic ev, input logic [6:0] c, input int cnt);
        if (!en || !ev) return 1'b0;
        if (!c[0]) return 1'b1;
        return (cnt % divisor(c)) == divisor(c) - 1;
    endfunction

    function automatic int nxt_cnt(input logic en, input logic ev, input logic [6:0] c, input int cnt);
        if (!en) return 0;
        if (!ev || !c[0]) return cnt;
        return (cnt + 1) % 65536;
    endfunction

    always @(posedge pclk21 or negedge n_p_reset21) begin
        if (!n_p_reset21) begin
            m_cnt  <= 0;
            m_tick <= 1'b0;
`ifdef TTC_EXT_CLK_EN
            hist   <= 3'b000;
            nedge  <= 0;
`endif
        end else begin
            m_tick <= nxt_tick(count_en21, model_event(), clk_ctrl_reg21, m_cnt);
            m_cnt  <= nxt_cnt(count_en21, model_event(), clk_ctrl_reg21, m_cnt);
`ifdef TTC_EXT_CLK_EN
            hist   <= {hist[1:0], ext_clk21};
            nedge  <= (nedge < 3) ? nedge + 1 : 3;
`endif
        end
    end

    always @(negedge pclk21) begin
        if (chk_on) begin
            vectors++;
            if (count_tick21 !== m_tick || prescale_cnt21 !== m_cnt[15:0]) begin
                miscompares++;
                $display("FAIL model t=%0t tick got %b exp %b cnt got %h exp %h",
                         $time, count_tick21, m_tick, prescale_cnt21, m_cnt[15:0]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0h exp %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk21);
        #1;
    endtask

    typedef struct {
        logic        en;
        logic [6:0]  ctrl;
        logic        tick;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int nticks;
        int hold;

        // Table: D=8 from a cleared counter, switch to D=2 mid-count, then no-prescale restart.
        for (int k = 0; k < 22; k++) tbl.push_back('{1'b1, 7'h05, logic'(k % 8 == 7), 16'(k + 1)});
        for (int k = 22; k < 26; k++) tbl.push_back('{1'b1, 7'h01, logic'(k % 2 == 1), 16'(k + 1)});
        tbl.push_back('{1'b0, 7'h00, 1'b0, 16'd0});
        tbl.push_back('{1'b1, 7'h00, 1'b1, 16'd0});
        tbl.push_back('{1'b1, 7'h00, 1'b1, 16'd0});
        tbl.push_back('{1'b0, 7'h00, 1'b0, 16'd0});
        tbl.push_back('{1'b1, 7'h00, 1'b1, 16'd0});
        tbl.push_back('{1'b1, 7'h00, 1'b1, 16'd0});

        // Reset with ext_clk21 high; no false edge after release.
        repeat (3) step();
        chk_on = 1'b1;
        check("reset_tick", 32'(count_tick21), 32'd0);
        check("reset_cnt", 32'(prescale_cnt21), 32'd0);
        n_p_reset21 = 1'b1;
        count_en21  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_tick", 32'(count_tick21), EXT_BUILT ? 32'd0 : 32'd1);
        end

        // Table-driven vectors
        count_en21 = 1'b0;
        clk_ctrl_reg21 = 7'h00;
        repeat (2) step();
        foreach (tbl[i]) begin
            count_en21 = tbl[i].en;
            clk_ctrl_reg21 = tbl[i].ctrl;
            step();
            check($sformatf("tbl%0d_tick", i), 32'(count_tick21), 32'(tbl[i].tick));
            check($sformatf("tbl%0d_cnt", i), 32'(prescale_cnt21), 32'(tbl[i].cnt));
        end

        // Wrap at D=65536: one tick, counter rolls FFFF -> 0000.
        clk_ctrl_reg21 = 7'h1F;
        count_en21 = 1'b0;
        step();
        count_en21 = 1'b1;
        nticks = 0;
        for (int i = 0; i < 65536; i++) begin
            step();
            if (count_tick21) nticks++;
            if (i == 65534) check("wrap_cnt_ffff", 32'(prescale_cnt21), 32'h0000FFFF);
        end
        check("wrap_cnt_zero", 32'(prescale_cnt21), 32'd0);
        check("wrap_last_tick", 32'(count_tick21), 32'd1);
        check("wrap_tick_count", 32'(nticks), 32'd1);

        // External source, rising then falling edges, 10-cycle ext period.
        clk_ctrl_reg21 = 7'h20;
        ext_clk21 = 1'b0;
        repeat (4) step();
        for (int sel = 0; sel < 2; sel++) begin
            clk_ctrl_reg21 = sel ? 7'h60 : 7'h20;
            for (int p = 0; p < 3; p++) begin
                ext_clk21 = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    step();
                    check(sel ? "ext_fall_hi" : "ext_rise_hi", 32'(count_tick21),
                          !EXT_BUILT ? 32'd1 : (sel == 0 && j == 2) ? 32'd1 : 32'd0);
                end
                ext_clk21 = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    step();
                    check(sel ? "ext_fall_lo" : "ext_rise_lo", 32'(count_tick21),
                          !EXT_BUILT ? 32'd1 : (sel == 1 && j == 2) ? 32'd1 : 32'd0);
                end
            end
        end
        clk_ctrl_reg21 = 7'h20;
        for (int j = 0; j < 6; j++) begin
            step();
            check("ext_idle", 32'(count_tick21), EXT_BUILT ? 32'd0 : 32'd1);
        end

        // Asynchronous reset mid-count clears without a clock edge.
        clk_ctrl_reg21 = 7'h03;
        count_en21 = 1'b0;
        step();
        count_en21 = 1'b1;
        repeat (6) step();
        check("pre_areset_cnt", 32'(prescale_cnt21), 32'd6);
        #2;
        n_p_reset21 = 1'b0;
        #1;
        check("areset_tick", 32'(count_tick21), 32'd0);
        check("areset_cnt", 32'(prescale_cnt21), 32'd0);
        repeat (2) step();
        n_p_reset21 = 1'b1;

        // Randomized traffic checked by the model every cycle.
        hold = 3;
        for (int i = 0; i < 3000; i++) begin
            count_en21 = ($urandom_range(0, 31) != 0);
            if ($urandom_range(0, 49) == 0)
                clk_ctrl_reg21 = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            hold--;
            if (hold == 0) begin
                ext_clk21 = ~ext_clk21;
                hold = $urandom_range(2, 6);
            end
            step();
        end

        step();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
